alu_op_issuer: RTL
==================

// Module: alu_op_issuer
// PURPOSE
//  Initiator side of the 16-bit ALU operand/opcode interface. Accepts tagged operation requests
//  over valid/ready, drives alu_a/alu_b/alu_opcode into the ALU, samples alu_result after
//  ALU_LAT cycles, and returns a tagged response over valid/ready. One op in flight.
//  Sits between the command source (sequencer/testbench driver) and the alu instance.
// PARAMETERS
//  W        16  operand/result width
//  TAG_W    4   request/response tag width
//  ALU_LAT  1   cycles alu_result needs after operands are driven (1 = combinational ALU); >=1
// PORTS
//  clk          in   1      single clock, all logic on posedge
//  rst          in   1      synchronous, active-high reset
//  req_valid    in   1      request present
//  req_ready    out  1      issuer can accept (IDLE only)
//  req_opcode   in   3      000 ADD,001 SUB,010 AND,011 OR,100 XOR,101 NOT(A),110/111 reserved
//  req_a        in   W      operand A
//  req_b        in   W      operand B (ignored for NOT)
//  req_tag      in   TAG_W  returned unchanged on resp_tag
//  alu_a        out  W      ALU operand A
//  alu_b        out  W      ALU operand B
//  alu_opcode   out  3      ALU opcode
//  alu_result   in   W      ALU result
//  resp_valid   out  1      response present
//  resp_ready   in   1      consumer accepts response
//  resp_data    out  W      captured result
//  resp_tag     out  TAG_W  tag of the op
//  resp_err     out  1      1 = reserved opcode rejected
//  busy         out  1      state != IDLE
//  chk_mismatch out  1      sticky golden-model mismatch (0 unless ALU_ISSUE_CHECK_EN)
// BEHAVIOUR
//  - Reset: state IDLE. alu_a=alu_b=0, alu_opcode=3'b110. resp_valid=0, resp_data=0, resp_tag=0.
//    resp_err=0, chk_mismatch=0, wait counter=0. req_ready=0 while rst is high.
//  - All outputs are registered except req_ready=(state==IDLE)&&!rst and busy=(state!=IDLE).
//  - FSM IDLE->DRIVE->RESP->IDLE; reserved path IDLE->RESP.
//  - IDLE: on req_valid&&req_ready latch opcode/a/b/tag.
//      Valid opcode: load alu_* with latched values, cnt=ALU_LAT-1, go DRIVE.
//      Reserved opcode (110/111): alu_* untouched, resp_data=0, resp_err=1, go RESP.
//  - DRIVE: alu_* held stable. If cnt==0: resp_data<=alu_result, resp_err<=0,
//    alu_opcode<=3'b110, alu_a/b<=0, go RESP. Else cnt--.
//  - RESP: resp_valid=1; data/tag/err held stable until resp_valid&&resp_ready; then go IDLE.
//    No request is accepted in the same cycle as a response handshake.
//  - Latency: accept at cycle N -> resp_valid at N+ALU_LAT+1 (reserved: N+1).
//    Min issue interval is ALU_LAT+2 cycles.
//  - Arithmetic is modulo 2^W (ALU wraps); the issuer never modifies the result.
//  - rst mid-op (DRIVE/RESP): op dropped, no response, state/outputs return to reset values next cycle.
//  - req_valid while not ready: ignored; the source must hold the request.
// CONFIGURATION
//  ALU_ISSUE_CHECK_EN defined: at DRIVE capture compare alu_result with alu_pkg::alu_golden(op,a,b).
//    On mismatch set chk_mismatch (sticky until rst); resp_data still carries the ALU value.
//  Not defined: no golden logic; chk_mismatch tied 0.
// STRUCTURE
//  alu_pkg: alu_op_e enum (ADD..NOT, RSVD), issuer_state_e {IDLE,DRIVE,RESP}, ALU_IDLE_OP=3'b110,
//    function alu_golden(op,a,b) (shared with the bench scoreboard).
//  Single module; no sub-module needed (the golden model is a package function).
// TESTING
//  1 rst high 2 cycles -> alu_opcode=110, resp_valid=0, req_ready=0; after release req_ready=1.
//  2 ADD a=16'hFFFF b=16'h0002 tag=3, ALU_LAT=1 -> resp at N+2: data=16'h0001, tag=3, err=0.
//  3 SUB a=5 b=7, resp_ready held 0 for 4 cycles -> data=16'hFFFE held stable; then IDLE.
//  4 opcode 111 a=9 tag=5 -> resp at N+1: err=1, data=0, tag=5; alu_* never leave idle values.
//  5 ALU_LAT=3, NOT a=16'h00F0 -> alu_* stable 3 cycles, data=16'hFF0F at N+4.
//  6 rst asserted in DRIVE -> no resp_valid; next op XOR 16'hAAAA^16'h5555 -> data=16'hFFFF.
//  7 CHECK_EN, ALU stub forces result=0 on ADD 1+1 -> chk_mismatch=1, stays 1 until rst.

Source files
------------

// File: rtl/alu_pkg.sv
// alu_pkg: ALU opcodes, issuer state encoding, idle opcode and golden ALU function
package alu_pkg;
    localparam int ALU_W = 16;
    typedef enum logic [2:0] {OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_NOT, OP_RSVD} alu_op_e;
    typedef logic [1:0] issuer_state_e;
    localparam issuer_state_e IDLE = 2'd0;
    localparam issuer_state_e DRIVE = 2'd1;
    localparam issuer_state_e RESP = 2'd2;
    localparam logic [2:0] ALU_IDLE_OP = 3'b110;
    function automatic logic [ALU_W-1:0] alu_golden(input logic [2:0] op, input logic [ALU_W-1:0] a, input logic [ALU_W-1:0] b);
        return op == OP_ADD ? a + b :
               op == OP_SUB ? a - b :
               op == OP_AND ? a & b :
               op == OP_OR  ? a | b :
               op == OP_XOR ? a ^ b :
               op == OP_NOT ? ~a : '0;
    endfunction
endpackage

// File: rtl/alu_op_issuer.sv
// alu_op_issuer: one-in-flight ALU op issuer with tagged valid/ready request/response; golden check via ALU_ISSUE_CHECK_EN
module alu_op_issuer import alu_pkg::*; #(
    parameter int W = 16,
    parameter int TAG_W = 4,
    parameter int ALU_LAT = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [2:0]       req_opcode,
    input  logic [W-1:0]     req_a,
    input  logic [W-1:0]     req_b,
    input  logic [TAG_W-1:0] req_tag,
    output logic [W-1:0]     alu_a,
    output logic [W-1:0]     alu_b,
    output logic [2:0]       alu_opcode,
    input  logic [W-1:0]     alu_result,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic [W-1:0]     resp_data,
    output logic [TAG_W-1:0] resp_tag,
    output logic             resp_err,
    output logic             busy,
    output logic             chk_mismatch
);
    localparam int CW = ALU_LAT > 1 ? $clog2(ALU_LAT) : 1;
    issuer_state_e state;
    logic [CW-1:0] cnt;
    assign req_ready = state == IDLE && !rst;
    assign busy = state != IDLE;
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt <= '0;
            alu_a <= '0;
            alu_b <= '0;
            alu_opcode <= ALU_IDLE_OP;
            resp_valid <= 1'b0;
            resp_data <= '0;
            resp_tag <= '0;
            resp_err <= 1'b0;
        end else begin
            case (state)
                IDLE: if (req_valid) begin
                    resp_tag <= req_tag;
                    if (req_opcode[2:1] == 2'b11) begin
                        resp_data <= '0;
                        resp_err <= 1'b1;
                        resp_valid <= 1'b1;
                        state <= RESP;
                    end else begin
                        alu_a <= req_a;
                        alu_b <= req_b;
                        alu_opcode <= req_opcode;
                        cnt <= CW'(ALU_LAT - 1);
                        state <= DRIVE;
                    end
                end
                DRIVE: if (cnt == '0) begin
                    resp_data <= alu_result;
                    resp_err <= 1'b0;
                    resp_valid <= 1'b1;
                    alu_opcode <= ALU_IDLE_OP;
                    alu_a <= '0;
                    alu_b <= '0;
                    state <= RESP;
                end else begin
                    cnt <= cnt - 1'b1;
                end
                RESP: if (resp_ready) begin
                    resp_valid <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
`ifdef ALU_ISSUE_CHECK_EN
    always_ff @(posedge clk) begin
        if (rst) chk_mismatch <= 1'b0;
        else if (state == DRIVE && cnt == '0 && alu_result != alu_golden(alu_opcode, alu_a, alu_b)) chk_mismatch <= 1'b1;
    end
`else
    assign chk_mismatch = 1'b0;
`endif
endmodule
